// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - counter-side bus of the time-set sequencer
interface time_set_ctrl_if;
  logic [4:0] q_hours;
  logic [5:0] q_minutes;
  logic [5:0] q_seconds;
  logic       load;
  logic [1:0] addrs;
  logic [5:0] data_in;
  logic       time_base_en;

  modport master (
    input  q_hours, q_minutes, q_seconds,
    output load, addrs, data_in, time_base_en
  );

  modport slave (
    output q_hours, q_minutes, q_seconds,
    input  load, addrs, data_in, time_base_en
  );
endinterface

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven time-set sequencer with shadow edit and sequential counter writes
module time_set_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tc_time_base,
  input  logic                  btn_mode,
  input  logic                  btn_up,
  input  logic                  btn_down,
  time_set_ctrl_if.master       cnt,
  output logic                  set_active,
  output logic [1:0]            field_sel,
  output logic [5:0]            shadow_value
);

  typedef enum logic [2:0] {
    S_IDLE, S_EDIT_H, S_EDIT_M, S_EDIT_S, S_WR_S, S_WR_M, S_WR_H
  } state_e;

  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT_TICKS - 1);

  state_e     state_q, state_d;
  logic [4:0] sh_h_q, sh_h_d;
  logic [5:0] sh_m_q, sh_m_d;
  logic [5:0] sh_s_q, sh_s_d;
  logic [5:0] tmo_q, tmo_d;

  logic       load_q, load_d;
  logic [1:0] addrs_q, addrs_d;
  logic [5:0] data_in_q, data_in_d;
  logic       time_base_en_q, time_base_en_d;
  logic       set_active_q, set_active_d;
  logic [1:0] field_sel_q, field_sel_d;
  logic [5:0] shadow_value_q, shadow_value_d;

  logic [5:0] fld, fld_max, fld_nxt;
  logic       any_btn;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      sh_h_q         <= 5'd0;
      sh_m_q         <= 6'd0;
      sh_s_q         <= 6'd0;
      tmo_q          <= 6'd0;
      load_q         <= 1'b0;
      addrs_q        <= 2'b00;
      data_in_q      <= 6'd0;
      time_base_en_q <= 1'b1;
      set_active_q   <= 1'b0;
      field_sel_q    <= 2'b11;
      shadow_value_q <= 6'd0;
    end else begin
      state_q        <= state_d;
      sh_h_q         <= sh_h_d;
      sh_m_q         <= sh_m_d;
      sh_s_q         <= sh_s_d;
      tmo_q          <= tmo_d;
      load_q         <= load_d;
      addrs_q        <= addrs_d;
      data_in_q      <= data_in_d;
      time_base_en_q <= time_base_en_d;
      set_active_q   <= set_active_d;
      field_sel_q    <= field_sel_d;
      shadow_value_q <= shadow_value_d;
    end
  end

  // Field arithmetic shared by the three edit states; out-of-range values snap to a legal bound.
  always_comb begin
    fld     = 6'd0;
    fld_max = 6'd59;
    case (state_q)
      S_EDIT_H: begin
        fld     = {1'b0, sh_h_q};
        fld_max = 6'd23;
      end
      S_EDIT_M: fld = sh_m_q;
      S_EDIT_S: fld = sh_s_q;
      default:  fld = 6'd0;
    endcase
    fld_nxt = fld;
    if (btn_up && !btn_down) begin
      fld_nxt = (fld >= fld_max) ? 6'd0 : fld + 6'd1;
    end else if (btn_down && !btn_up) begin
      fld_nxt = (fld == 6'd0 || fld > fld_max) ? fld_max : fld - 6'd1;
    end
  end

  assign any_btn = btn_mode | btn_up | btn_down;

  always_comb begin
    state_d = state_q;
    sh_h_d  = sh_h_q;
    sh_m_d  = sh_m_q;
    sh_s_d  = sh_s_q;
    tmo_d   = 6'd0;
    case (state_q)
      S_IDLE: begin
        if (btn_mode) begin
          sh_h_d  = cnt.q_hours;
          sh_m_d  = cnt.q_minutes;
          sh_s_d  = cnt.q_seconds;
          state_d = S_EDIT_H;
        end
      end
      S_EDIT_H, S_EDIT_M, S_EDIT_S: begin
        if (btn_mode) begin
          case (state_q)
            S_EDIT_H: state_d = S_EDIT_M;
            S_EDIT_M: state_d = S_EDIT_S;
            default:  state_d = S_WR_S;
          endcase
        end else begin
          case (state_q)
            S_EDIT_H: sh_h_d = fld_nxt[4:0];
            S_EDIT_M: sh_m_d = fld_nxt;
            default:  sh_s_d = fld_nxt;
          endcase
          if (!any_btn && tc_time_base) begin
            if (tmo_q == TMO_LAST) begin
              state_d = S_IDLE;
            end else begin
              tmo_d = tmo_q + 6'd1;
            end
          end else if (!any_btn) begin
            tmo_d = tmo_q;
          end
        end
      end
      S_WR_S:  state_d = S_WR_M;
      S_WR_M:  state_d = S_WR_H;
      S_WR_H:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    load_d         = 1'b0;
    addrs_d        = 2'b00;
    data_in_d      = 6'd0;
    time_base_en_d = (state_d == S_IDLE);
    set_active_d   = (state_d != S_IDLE);
    field_sel_d    = 2'b11;
    shadow_value_d = 6'd0;
    case (state_d)
      S_EDIT_H: begin
        field_sel_d    = 2'b10;
        shadow_value_d = {1'b0, sh_h_d};
      end
      S_EDIT_M: begin
        field_sel_d    = 2'b01;
        shadow_value_d = sh_m_d;
      end
      S_EDIT_S: begin
        field_sel_d    = 2'b00;
        shadow_value_d = sh_s_d;
      end
      S_WR_S: begin
        load_d    = 1'b1;
        addrs_d   = 2'b00;
        data_in_d = sh_s_d;
      end
      S_WR_M: begin
        load_d    = 1'b1;
        addrs_d   = 2'b01;
        data_in_d = sh_m_d;
      end
      S_WR_H: begin
        load_d    = 1'b1;
        addrs_d   = 2'b10;
        data_in_d = {1'b0, sh_h_d};
      end
      default: begin
        load_d = 1'b0;
      end
    endcase
  end

  assign cnt.load         = load_q;
  assign cnt.addrs        = addrs_q;
  assign cnt.data_in      = data_in_q;
  assign cnt.time_base_en = time_base_en_q;
  assign set_active       = set_active_q;
  assign field_sel        = field_sel_q;
  assign shadow_value     = shadow_value_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - table-driven and directed-sequence bench for time_set_ctrl
module tb_time_set_ctrl;
  localparam int TMO = 30;

  logic       clk = 1'b0;
  logic       reset, tick, mode, up, down;
  logic       set_active;
  logic [1:0] field_sel;
  logic [5:0] shadow_value;
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;
  logic       load_seen = 1'b0;

  time_set_ctrl_if bus ();

  time_set_ctrl #(.TIMEOUT_TICKS(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .tc_time_base (tick),
    .btn_mode     (mode),
    .btn_up       (up),
    .btn_down     (down),
    .cnt          (bus),
    .set_active   (set_active),
    .field_sel    (field_sel),
    .shadow_value (shadow_value)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mon_en && bus.load) load_seen = 1'b1;

  typedef struct {
    logic       rst, tk, md, u, d;
    logic [4:0] qh;
    logic [5:0] qm, qs;
    logic       ld;
    logic [1:0] ad;
    logic [5:0] dt;
    logic       tbe, sa;
    logic [1:0] fs;
    logic [5:0] sv;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic tk, logic md, logic u, logic d,
                              logic [4:0] qh, logic [5:0] qm, logic [5:0] qs,
                              logic ld, logic [1:0] ad, logic [5:0] dt,
                              logic tbe, logic sa, logic [1:0] fs, logic [5:0] sv);
    vec_t v;
    v.rst = rst; v.tk = tk; v.md = md; v.u = u; v.d = d;
    v.qh = qh; v.qm = qm; v.qs = qs;
    v.ld = ld; v.ad = ad; v.dt = dt; v.tbe = tbe; v.sa = sa; v.fs = fs; v.sv = sv;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(logic rst, logic tk, logic md, logic u, logic d);
    reset = rst; tick = tk; mode = md; up = u; down = d;
    @(posedge clk);
    #1;
  endtask

  task automatic set_q(int h, int m, int s);
    bus.q_hours = 5'(h); bus.q_minutes = 6'(m); bus.q_seconds = 6'(s);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; mode = 1'b0; up = 1'b0; down = 1'b0;
    set_q(0, 0, 0);

    // rst tk md u d | qh qm qs | ld ad dt tbe sa fs sv
    vecs.push_back(mk(1,0,0,0,0, 12,34,56, 0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,1,0,0, 12,34,56, 0,0,0, 0,1,2,12));
    vecs.push_back(mk(0,0,0,1,0, 12,34,56, 0,0,0, 0,1,2,13));
    vecs.push_back(mk(0,0,0,0,1, 12,34,56, 0,0,0, 0,1,2,12));
    vecs.push_back(mk(0,0,1,0,0, 12,34,56, 0,0,0, 0,1,1,34));
    vecs.push_back(mk(0,0,0,0,1, 12,34,56, 0,0,0, 0,1,1,33));
    vecs.push_back(mk(0,0,1,0,0, 12,34,56, 0,0,0, 0,1,0,56));
    vecs.push_back(mk(0,0,0,1,0, 12,34,56, 0,0,0, 0,1,0,57));
    vecs.push_back(mk(0,0,0,1,1, 12,34,56, 0,0,0, 0,1,0,57));
    vecs.push_back(mk(0,1,1,1,0, 12,34,56, 1,0,57, 0,1,3,0));
    vecs.push_back(mk(0,0,0,1,0, 12,34,56, 1,1,33, 0,1,3,0));
    vecs.push_back(mk(0,0,0,0,0, 12,34,56, 1,2,12, 0,1,3,0));
    vecs.push_back(mk(0,0,0,0,0, 12,34,56, 0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,1,0,1,1, 12,34,56, 0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,1,0,0, 23,0,59,  0,0,0, 0,1,2,23));
    vecs.push_back(mk(0,0,0,1,0, 23,0,59,  0,0,0, 0,1,2,0));
    vecs.push_back(mk(0,0,0,0,1, 23,0,59,  0,0,0, 0,1,2,23));
    vecs.push_back(mk(0,0,0,1,1, 23,0,59,  0,0,0, 0,1,2,23));
    vecs.push_back(mk(1,0,0,0,0, 23,0,59,  0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,1,0,0, 6,58,1,   0,0,0, 0,1,2,6));
    vecs.push_back(mk(0,0,0,1,0, 6,58,1,   0,0,0, 0,1,2,7));
    vecs.push_back(mk(0,0,1,0,0, 6,58,1,   0,0,0, 0,1,1,58));
    vecs.push_back(mk(0,0,0,1,0, 6,58,1,   0,0,0, 0,1,1,59));
    vecs.push_back(mk(0,0,1,0,0, 6,58,1,   0,0,0, 0,1,0,1));
    vecs.push_back(mk(0,0,0,0,1, 6,58,1,   0,0,0, 0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1, 6,58,1,   0,0,0, 0,1,0,59));
    vecs.push_back(mk(0,0,0,1,0, 6,58,1,   0,0,0, 0,1,0,0));
    vecs.push_back(mk(0,0,1,0,0, 6,58,1,   1,0,0, 0,1,3,0));
    vecs.push_back(mk(0,0,0,0,0, 6,58,1,   1,1,59, 0,1,3,0));
    vecs.push_back(mk(0,0,0,0,0, 6,58,1,   1,2,7, 0,1,3,0));
    vecs.push_back(mk(0,0,0,0,0, 6,58,1,   0,0,0, 1,0,3,0));
    vecs.push_back(mk(0,0,1,0,0, 31,63,0,  0,0,0, 0,1,2,31));
    vecs.push_back(mk(0,0,0,0,1, 31,63,0,  0,0,0, 0,1,2,23));
    vecs.push_back(mk(0,0,1,0,0, 31,63,0,  0,0,0, 0,1,1,63));
    vecs.push_back(mk(0,0,0,1,0, 31,63,0,  0,0,0, 0,1,1,0));
    vecs.push_back(mk(1,0,0,0,0, 31,63,0,  0,0,0, 1,0,3,0));

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      set_q(int'(vecs[i].qh), int'(vecs[i].qm), int'(vecs[i].qs));
      cyc(vecs[i].rst, vecs[i].tk, vecs[i].md, vecs[i].u, vecs[i].d);
      chk($sformatf("v%0d.load", i), int'(bus.load), int'(vecs[i].ld));
      chk($sformatf("v%0d.addrs", i), int'(bus.addrs), int'(vecs[i].ad));
      chk($sformatf("v%0d.data_in", i), int'(bus.data_in), int'(vecs[i].dt));
      chk($sformatf("v%0d.time_base_en", i), int'(bus.time_base_en), int'(vecs[i].tbe));
      chk($sformatf("v%0d.set_active", i), int'(set_active), int'(vecs[i].sa));
      chk($sformatf("v%0d.field_sel", i), int'(field_sel), int'(vecs[i].fs));
      chk($sformatf("v%0d.shadow_value", i), int'(shadow_value), int'(vecs[i].sv));
    end

    // Timeout abort from EDIT_M after TMO idle ticks, no writes issued
    set_q(1, 2, 3);
    cyc(1,0,0,0,0);
    cyc(0,0,1,0,0);
    cyc(0,0,1,0,0);
    chk("to.enter_m", int'(field_sel), 1);
    load_seen = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < TMO - 1; i++) cyc(0,1,0,0,0);
    chk("to.before_last", int'(set_active), 1);
    cyc(0,0,0,0,0);
    chk("to.no_tick_hold", int'(set_active), 1);
    cyc(0,1,0,0,0);
    chk("to.abort_sa", int'(set_active), 0);
    chk("to.abort_fs", int'(field_sel), 3);
    chk("to.abort_tbe", int'(bus.time_base_en), 1);
    cyc(0,0,0,0,0);
    mon_en = 1'b0;
    chk("to.no_load", int'(load_seen), 0);

    // Up pulse coincident with tick TMO-1 clears the counter
    cyc(1,0,0,0,0);
    cyc(0,0,1,0,0);
    cyc(0,0,1,0,0);
    for (int i = 0; i < TMO - 2; i++) cyc(0,1,0,0,0);
    cyc(0,1,0,1,0);
    chk("tc.still_m", int'(field_sel), 1);
    chk("tc.up_val", int'(shadow_value), 3);
    for (int i = 0; i < TMO - 1; i++) cyc(0,1,0,0,0);
    chk("tc.after_refill", int'(set_active), 1);
    cyc(0,1,0,0,0);
    chk("tc.abort", int'(set_active), 0);

    // Reset during WR_M suppresses the WR_H pulse
    cyc(1,0,0,0,0);
    cyc(0,0,1,0,0);
    cyc(0,0,1,0,0);
    cyc(0,0,1,0,0);
    cyc(0,0,1,0,0);
    chk("rw.wr_s", int'(bus.load), 1);
    cyc(0,0,0,0,0);
    chk("rw.wr_m_addr", int'(bus.addrs), 1);
    chk("rw.wr_m_data", int'(bus.data_in), 2);
    cyc(1,0,0,0,0);
    chk("rw.rst_load", int'(bus.load), 0);
    chk("rw.rst_sa", int'(set_active), 0);
    chk("rw.rst_tbe", int'(bus.time_base_en), 1);
    cyc(0,0,0,0,0);
    chk("rw.no_wr_h", int'(bus.load), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
